// File: rtl/song_sequencer.sv
// song_sequencer
//
// Playback controller for the note lanes. Divides clock down to the beat
// period, runs the song life-cycle and emits the single-cycle strobes that
// reload and advance the three lane shift registers.
//
// Ports
//   clock          system clock
//   reset_b        asynchronous active-low reset
//   start          level; request to (re)start a song from IDLE or DONE
//   pause_toggle   pulse; PLAYING <-> PAUSED
//   stop           pulse; abort to IDLE from any state
//   speed_sel[1:0] tempo select, 0 slowest .. 3 fastest, latched at start
//   load_song      pulse; lanes reload their song patterns
//   shift_en       pulse; lanes shift by one note
//   count_in_beat  pulse; one per silent count-in beat
//   beat_index[6:0] shift pulses issued in the current song
//   playing / paused / song_done   state flags
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start, no pulses
// S_COUNTIN | silent beats, count_in_beat on each divider wrap
// S_PLAYING | shift_en on each divider wrap, beat_index counts up
// S_PAUSED  | divider frozen mid-period, no pulses
// S_DONE    | song finished, beat_index holds SONG_LEN

module song_sequencer #(
    parameter int unsigned BASE_DIV = 3_125_000,
    parameter int unsigned SONG_LEN = 100,
    parameter int unsigned COUNT_IN = 4
) (
    input  logic       clock,
    input  logic       reset_b,
    input  logic       start,
    input  logic       pause_toggle,
    input  logic       stop,
    input  logic [1:0] speed_sel,
    output logic       load_song,
    output logic       shift_en,
    output logic       count_in_beat,
    output logic [6:0] beat_index,
    output logic       playing,
    output logic       paused,
    output logic       song_done
);

    // Longest period is BASE_DIV*4; the divider only ever holds 0..P-1.
    localparam int unsigned P_MAX = BASE_DIV * 4;
    localparam int unsigned DIV_W = $clog2(P_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNTIN,
        S_PLAYING,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [DIV_W-1:0] period_m1, period_m1_nxt;
    logic [3:0]       cin_cnt, cin_nxt;
    logic [6:0]       beat_nxt;
    logic             load_nxt, shift_nxt, cin_beat_nxt;
    logic             wrap, last_beat, song_full;

    assign wrap      = (div_cnt == period_m1);
    assign last_beat = ((beat_index + 7'd1) == 7'(SONG_LEN));
    assign song_full = (beat_index == 7'(SONG_LEN));

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state         <= S_IDLE;
            div_cnt       <= '0;
            period_m1     <= '0;
            cin_cnt       <= '0;
            beat_index    <= '0;
            load_song     <= 1'b0;
            shift_en      <= 1'b0;
            count_in_beat <= 1'b0;
            playing       <= 1'b0;
            paused        <= 1'b0;
            song_done     <= 1'b0;
        end else begin
            state         <= state_nxt;
            div_cnt       <= div_nxt;
            period_m1     <= period_m1_nxt;
            cin_cnt       <= cin_nxt;
            beat_index    <= beat_nxt;
            load_song     <= load_nxt;
            shift_en      <= shift_nxt;
            count_in_beat <= cin_beat_nxt;
            playing       <= (state_nxt == S_PLAYING);
            paused        <= (state_nxt == S_PAUSED);
            song_done     <= (state_nxt == S_DONE);
        end
    end

    always_comb begin
        state_nxt     = state;
        div_nxt       = div_cnt;
        period_m1_nxt = period_m1;
        cin_nxt       = cin_cnt;
        beat_nxt      = beat_index;
        load_nxt      = 1'b0;
        shift_nxt     = 1'b0;
        cin_beat_nxt  = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                // start wins over a simultaneous pause_toggle, which is dropped
                if (start) begin
                    state_nxt     = (COUNT_IN == 0) ? S_PLAYING : S_COUNTIN;
                    load_nxt      = 1'b1;
                    div_nxt       = '0;
                    beat_nxt      = '0;
                    cin_nxt       = 4'(COUNT_IN);
                    period_m1_nxt = DIV_W'(BASE_DIV * (32'd4 - 32'(speed_sel)) - 32'd1);
                end
            end
            S_COUNTIN: begin
                if (wrap) begin
                    div_nxt      = '0;
                    cin_beat_nxt = 1'b1;
                    cin_nxt      = cin_cnt - 4'd1;
                    if (cin_cnt == 4'd1) begin
                        state_nxt = S_PLAYING;
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            S_PLAYING: begin
                // DONE is entered the cycle after the final shift_en
                if (song_full) begin
                    state_nxt = S_DONE;
                end else if (wrap) begin
                    div_nxt   = '0;
                    shift_nxt = 1'b1;
                    beat_nxt  = beat_index + 7'd1;
                    if (pause_toggle && !last_beat) begin
                        state_nxt = S_PAUSED;
                    end
                end else begin
                    // the toggle cycle itself still counts, so no phase is lost
                    div_nxt = div_cnt + DIV_W'(1);
                    if (pause_toggle) begin
                        state_nxt = S_PAUSED;
                    end
                end
            end
            S_PAUSED: begin
                if (pause_toggle) begin
                    state_nxt = S_PLAYING;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (stop) begin
            state_nxt    = S_IDLE;
            div_nxt      = '0;
            beat_nxt     = '0;
            load_nxt     = 1'b0;
            shift_nxt    = 1'b0;
            cin_beat_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: DUT a (COUNT_IN=2) and DUT b (COUNT_IN=0),
// both BASE_DIV=2, SONG_LEN=4. Pulses are scored against an expected queue;
// state flags are checked from per-scenario vector tables.

module tb_song_sequencer;

    logic       clock = 1'b0;
    logic       reset_b;
    logic       start, pause_toggle, stop;
    logic [1:0] speed_sel;
    logic       load_song, shift_en, count_in_beat;
    logic [6:0] beat_index;
    logic       playing, paused, song_done;

    logic       b_start, b_pause, b_stop;
    logic [1:0] b_speed;
    logic       b_load, b_shift, b_cin;
    logic [6:0] b_bi;
    logic       b_playing, b_paused, b_done;

    song_sequencer #(.BASE_DIV(2), .SONG_LEN(4), .COUNT_IN(2)) dut_a (
        .clock(clock), .reset_b(reset_b), .start(start), .pause_toggle(pause_toggle),
        .stop(stop), .speed_sel(speed_sel), .load_song(load_song), .shift_en(shift_en),
        .count_in_beat(count_in_beat), .beat_index(beat_index), .playing(playing),
        .paused(paused), .song_done(song_done)
    );

    song_sequencer #(.BASE_DIV(2), .SONG_LEN(4), .COUNT_IN(0)) dut_b (
        .clock(clock), .reset_b(reset_b), .start(b_start), .pause_toggle(b_pause),
        .stop(b_stop), .speed_sel(b_speed), .load_song(b_load), .shift_en(b_shift),
        .count_in_beat(b_cin), .beat_index(b_bi), .playing(b_playing),
        .paused(b_paused), .song_done(b_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         st, pt, sp;
        logic [1:0] spd;
        int         song_p;   // nonzero: push a full default song with this period
        bit         e_play, e_paused, e_done;
        logic [6:0] e_bi;
    } vec_t;

    typedef struct {
        int         cyc;
        int         kind;     // 0 load_song, 1 count_in_beat, 2 shift_en
        logic [6:0] bi;
    } pulse_t;

    vec_t   vecs[$];
    pulse_t qa[$];
    pulse_t qb[$];
    int     checks = 0;
    int     failures = 0;
    int     t0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] kind_bits(input int k);
        case (k)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic push_a(input int c, input int k, input int bi);
        pulse_t p;
        p = '{c, k, 7'(bi)};
        qa.push_back(p);
    endtask

    task automatic push_b(input int c, input int k, input int bi);
        pulse_t p;
        p = '{c, k, 7'(bi)};
        qb.push_back(p);
    endtask

    // DUT a default song: start at ts, two count-in beats, four shifts
    task automatic push_song_a(input int ts, input int p);
        push_a(ts + 1, 0, 0);
        for (int k = 1; k <= 2; k++) push_a(ts + 1 + k * p, 1, 0);
        for (int k = 1; k <= 4; k++) push_a(ts + 1 + (2 + k) * p, 2, k);
    endtask

    task automatic monitor();
        pulse_t e;
        if (load_song | count_in_beat | shift_en) begin
            if (qa.size() != 0) e = qa.pop_front();
            else e = '{-1, -1, 7'd0};
            check("a_pulse_cycle", cyc, e.cyc);
            check("a_pulse_kind", {load_song, count_in_beat, shift_en}, kind_bits(e.kind));
            check("a_pulse_beat_index", beat_index, e.bi);
        end
        if (b_load | b_cin | b_shift) begin
            if (qb.size() != 0) e = qb.pop_front();
            else e = '{-1, -1, 7'd0};
            check("b_pulse_cycle", cyc, e.cyc);
            check("b_pulse_kind", {b_load, b_cin, b_shift}, kind_bits(e.kind));
            check("b_pulse_beat_index", b_bi, e.bi);
        end
    endtask

    task automatic half_a();
        @(negedge clock);
        monitor();
    endtask

    task automatic half_b();
        @(posedge clock);
        #1;
        start = 1'b0; pause_toggle = 1'b0; stop = 1'b0; b_start = 1'b0;
    endtask

    task automatic advance_to(input int target);
        while (cyc < target) begin
            half_a();
            half_b();
        end
    endtask

    task automatic add_vec(input int c, input bit st, input bit pt, input bit sp,
                           input logic [1:0] spd, input int song_p,
                           input bit pl, input bit pa, input bit dn, input int bi);
        vec_t v;
        v = '{c, st, pt, sp, spd, song_p, pl, pa, dn, 7'(bi)};
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            advance_to(t0 + vecs[i].cyc);
            start = vecs[i].st; pause_toggle = vecs[i].pt; stop = vecs[i].sp;
            speed_sel = vecs[i].spd;
            if (vecs[i].song_p != 0) push_song_a(cyc, vecs[i].song_p);
            half_a();
            check($sformatf("%s_flags_c%0d", tag, vecs[i].cyc),
                  {playing, paused, song_done, beat_index},
                  {vecs[i].e_play, vecs[i].e_paused, vecs[i].e_done, vecs[i].e_bi});
            half_b();
        end
        vecs.delete();
        check({tag, "_queue_drained"}, qa.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_b = 1'b1;
        start = 1'b0; pause_toggle = 1'b0; stop = 1'b0; speed_sel = 2'd0;
        b_start = 1'b0; b_pause = 1'b0; b_stop = 1'b0; b_speed = 2'd0;
        #2 reset_b = 1'b0;
        #10;
        check("reset_outputs_a",
              {load_song, shift_en, count_in_beat, beat_index, playing, paused, song_done}, 0);
        check("reset_outputs_b", {b_load, b_shift, b_cin, b_bi, b_playing, b_paused, b_done}, 0);
        @(posedge clock);
        #1 reset_b = 1'b1;
        half_b();

        // basic song from IDLE, P=8
        t0 = cyc;
        add_vec(0, 1, 0, 0, 0, 8, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(17, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add_vec(24, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add_vec(25, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add_vec(49, 0, 0, 0, 0, 0, 1, 0, 0, 4);
        add_vec(50, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        add_vec(55, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        run_vecs("song1");

        // restart from DONE at speed 3 (P=2), speed changed mid-song
        t0 = cyc;
        add_vec(0, 1, 0, 0, 3, 2, 0, 0, 1, 4);
        add_vec(1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        add_vec(5, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add_vec(7, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add_vec(13, 0, 0, 0, 0, 0, 1, 0, 0, 4);
        add_vec(14, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        add_vec(20, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        run_vecs("speed");

        // pause mid-period, resume, start ignored while paused and playing
        t0 = cyc;
        push_a(t0 + 1, 0, 0); push_a(t0 + 9, 1, 0); push_a(t0 + 17, 1, 0);
        push_a(t0 + 25, 2, 1); push_a(t0 + 105, 2, 2);
        push_a(t0 + 113, 2, 3); push_a(t0 + 121, 2, 4);
        add_vec(0, 1, 0, 0, 0, 0, 0, 0, 1, 4);
        add_vec(28, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        add_vec(29, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        add_vec(60, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        add_vec(100, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        add_vec(101, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add_vec(104, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add_vec(105, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        add_vec(110, 1, 0, 0, 0, 0, 1, 0, 0, 2);
        add_vec(121, 0, 0, 0, 0, 0, 1, 0, 0, 4);
        add_vec(122, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        run_vecs("pause");

        // stop mid-song, later restart, then stop+start together
        t0 = cyc;
        push_a(t0 + 1, 0, 0); push_a(t0 + 9, 1, 0); push_a(t0 + 17, 1, 0);
        push_a(t0 + 25, 2, 1);
        add_vec(0, 1, 0, 0, 0, 0, 0, 0, 1, 4);
        add_vec(30, 0, 0, 1, 0, 0, 1, 0, 0, 1);
        add_vec(31, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(60, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(70, 1, 0, 0, 0, 8, 0, 0, 0, 0);
        add_vec(71, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(95, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add_vec(119, 0, 0, 0, 0, 0, 1, 0, 0, 4);
        add_vec(120, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        add_vec(130, 1, 0, 1, 0, 0, 0, 0, 1, 4);
        add_vec(131, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(140, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_vecs("stop");

        // pause on a wrap cycle, and on the final wrap (pause dropped)
        t0 = cyc;
        push_a(t0 + 1, 0, 0); push_a(t0 + 9, 1, 0); push_a(t0 + 17, 1, 0);
        push_a(t0 + 25, 2, 1); push_a(t0 + 49, 2, 2);
        push_a(t0 + 57, 2, 3); push_a(t0 + 65, 2, 4);
        add_vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(24, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        add_vec(25, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        add_vec(40, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        add_vec(41, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add_vec(49, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        add_vec(64, 0, 1, 0, 0, 0, 1, 0, 0, 3);
        add_vec(65, 0, 0, 0, 0, 0, 1, 0, 0, 4);
        add_vec(66, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        run_vecs("pausewrap");

        // asynchronous reset while a count_in_beat is high
        t0 = cyc;
        push_a(t0 + 1, 0, 0);
        add_vec(0, 1, 0, 0, 0, 0, 0, 0, 1, 4);
        add_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_vecs("rst_pre");
        advance_to(t0 + 9);
        check("pre_reset_count_in_beat", count_in_beat, 1);
        #1 reset_b = 1'b0;
        #1;
        check("async_reset_outputs",
              {load_song, shift_en, count_in_beat, beat_index, playing, paused, song_done}, 0);
        for (int i = 0; i < 3; i++) begin
            half_a();
            half_b();
        end
        reset_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            half_a();
            half_b();
        end
        check("no_restart_without_start",
              {load_song, shift_en, count_in_beat, beat_index, playing, paused, song_done}, 0);

        // DUT b: no count-in, first shift P cycles after load_song
        t0 = cyc;
        push_b(t0 + 1, 0, 0);
        for (int k = 1; k <= 4; k++) push_b(t0 + 1 + k * 8, 2, k);
        b_start = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            half_a();
            if (i == 1)  check("b_playing_after_load", {b_playing, b_bi}, {1'b1, 7'd0});
            if (i == 33) check("b_last_beat", {b_playing, b_done, b_bi}, {1'b1, 1'b0, 7'd4});
            if (i == 34) check("b_song_done", {b_playing, b_done, b_bi}, {1'b0, 1'b1, 7'd4});
            half_b();
        end
        check("b_queue_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
